// File: rtl/n_bf_dit_pipe_pkg.sv
// Shared widths, Q8.8 constants and the complex-sample type for the DIT butterfly.
package n_bf_dit_pipe_pkg;

    localparam int DEF_DW   = 16;
    localparam int DEF_FRAC = 8;

    localparam logic [DEF_DW-1:0] ONE     = 16'h0100;
    localparam logic [DEF_DW-1:0] NEG_ONE = 16'hFF00;

    typedef struct packed {
        logic [DEF_DW-1:0] re;
        logic [DEF_DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/n_mult.sv
// Signed W x W -> 2W multiplier, purely combinational; callers register the result.
module n_mult #(
    parameter int W = 16
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    assign p = (2*W)'($signed(a)) * (2*W)'($signed(b));

endmodule

// File: rtl/n_bf_dit_pipe.sv
// Three-stage radix-2 DIT butterfly: out1 = A + W*B, out2 = A - W*B.
// One global enable stalls every stage together, so bubbles travel as invalid slots.
module n_bf_dit_pipe
    import n_bf_dit_pipe_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int FRAC  = DEF_FRAC,
    parameter int SCALE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          inv,
    input  logic [DW-1:0] a_r,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_r,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] w_r,
    input  logic [DW-1:0] w_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out1_r,
    output logic [DW-1:0] out1_i,
    output logic [DW-1:0] out2_r,
    output logic [DW-1:0] out2_i
);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cx_t;

    logic          en;
    logic          v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
    cx_t           a1_q, a1_d, b1_q, b1_d, w1_q, w1_d;
    cx_t           a2_q, a2_d;
    logic [2*DW-1:0] p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;
    logic [2*DW-1:0] m_rr, m_ii, m_ri, m_ir;
    cx_t           o1_q, o1_d, o2_q, o2_d;

    logic [2*DW-1:0] pr, pi;
    logic [DW-1:0]   p_r, p_i;
    logic [DW:0]     s1_r, s1_i, s2_r, s2_i;

    // SCALE=1 keeps the extra sum bit and drops the LSB, i.e. floor(sum/2).
    function automatic logic [DW-1:0] pick(input logic [DW:0] s);
        return (SCALE != 0) ? s[DW:1] : s[DW-1:0];
    endfunction

    n_mult #(.W(DW)) u_m_rr (.a(b1_q.re), .b(w1_q.re), .p(m_rr));
    n_mult #(.W(DW)) u_m_ii (.a(b1_q.im), .b(w1_q.im), .p(m_ii));
    n_mult #(.W(DW)) u_m_ri (.a(b1_q.re), .b(w1_q.im), .p(m_ri));
    n_mult #(.W(DW)) u_m_ir (.a(b1_q.im), .b(w1_q.re), .p(m_ir));

    always_comb begin
        pr   = p_rr_q - p_ii_q;
        pi   = p_ri_q + p_ir_q;
        p_r  = DW'(pr >> FRAC);
        p_i  = DW'(pi >> FRAC);
        s1_r = {a2_q.re[DW-1], a2_q.re} + {p_r[DW-1], p_r};
        s1_i = {a2_q.im[DW-1], a2_q.im} + {p_i[DW-1], p_i};
        s2_r = {a2_q.re[DW-1], a2_q.re} - {p_r[DW-1], p_r};
        s2_i = {a2_q.im[DW-1], a2_q.im} - {p_i[DW-1], p_i};
    end

    always_comb begin
        en     = !ov_q || out_ready;
        v1_d   = v1_q;
        v2_d   = v2_q;
        ov_d   = ov_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        w1_d   = w1_q;
        a2_d   = a2_q;
        p_rr_d = p_rr_q;
        p_ii_d = p_ii_q;
        p_ri_d = p_ri_q;
        p_ir_d = p_ir_q;
        o1_d   = o1_q;
        o2_d   = o2_q;
        if (en) begin
            v1_d = in_valid;
            v2_d = v1_q;
            ov_d = v2_q;
            if (in_valid) begin
                a1_d = '{re: a_r, im: a_i};
                b1_d = '{re: b_r, im: b_i};
                // Inverse mode uses conj(W); -(-2^(DW-1)) wraps back to itself.
                w1_d = '{re: w_r, im: inv ? -w_i : w_i};
            end
            if (v1_q) begin
                a2_d   = a1_q;
                p_rr_d = m_rr;
                p_ii_d = m_ii;
                p_ri_d = m_ri;
                p_ir_d = m_ir;
            end
            if (v2_q) begin
                o1_d = '{re: pick(s1_r), im: pick(s1_i)};
                o2_d = '{re: pick(s2_r), im: pick(s2_i)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            ov_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            w1_q   <= '0;
            a2_q   <= '0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            o1_q   <= '0;
            o2_q   <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            ov_q   <= ov_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            w1_q   <= w1_d;
            a2_q   <= a2_d;
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
            o1_q   <= o1_d;
            o2_q   <= o2_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = ov_q;
    assign out1_r    = o1_q.re;
    assign out1_i    = o1_q.im;
    assign out2_r    = o2_q.re;
    assign out2_i    = o2_q.im;

endmodule

// File: tb/tb_n_bf_dit_pipe.sv
// Bench for n_bf_dit_pipe: an unscaled and a scaled instance share one stimulus stream
// and are checked against an integer-arithmetic butterfly model.
module tb_n_bf_dit_pipe;
    import n_bf_dit_pipe_pkg::*;

    typedef struct packed {
        cplx_t a;
        cplx_t b;
        cplx_t w;
        logic  inv;
    } op_t;

    typedef struct packed {
        logic [15:0] o1r;
        logic [15:0] o1i;
        logic [15:0] o2r;
        logic [15:0] o2i;
    } res_t;

    typedef struct {
        logic ov0;
        logic ov1;
        logic ir0;
        logic ir1;
        res_t d0;
        res_t d1;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        inv = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0, w_r = '0, w_i = '0;
    logic        ir0, ir1, ov0, ov1;
    logic [15:0] x1r, x1i, x2r, x2i;
    logic [15:0] y1r, y1i, y2r, y2i;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t q0[$];
    res_t q1[$];

    always #5 clk = ~clk;

    n_bf_dit_pipe #(.DW(16), .FRAC(8), .SCALE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .inv(inv),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .w_r(w_r), .w_i(w_i),
        .out_valid(ov0), .out_ready(out_ready),
        .out1_r(x1r), .out1_i(x1i), .out2_r(x2r), .out2_i(x2i)
    );

    n_bf_dit_pipe #(.DW(16), .FRAC(8), .SCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .inv(inv),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .w_r(w_r), .w_i(w_i),
        .out_valid(ov1), .out_ready(out_ready),
        .out1_r(y1r), .out1_i(y1i), .out2_r(y2r), .out2_i(y2i)
    );

    function automatic logic [15:0] w16(input longint x);
        return x[15:0];
    endfunction

    // Reference: complex arithmetic on plain integers, truncation as floor(x/256).
    function automatic res_t model(input op_t o, input int sc);
        longint ar, ai, br, bi, wr, wi, pr, pi, p_r, p_i, v;
        longint s[4];
        res_t r;
        ar = $signed(o.a.re);
        ai = $signed(o.a.im);
        br = $signed(o.b.re);
        bi = $signed(o.b.im);
        wr = $signed(o.w.re);
        wi = $signed(o.w.im);
        if (o.inv) wi = -wi;
        if (wi == 32768) wi = -32768;
        pr  = br * wr - bi * wi;
        pi  = br * wi + bi * wr;
        p_r = longint'($signed(w16(pr >>> 8)));
        p_i = longint'($signed(w16(pi >>> 8)));
        s[0] = ar + p_r;
        s[1] = ai + p_i;
        s[2] = ar - p_r;
        s[3] = ai - p_i;
        for (int k = 0; k < 4; k++) begin
            v = (sc != 0) ? (s[k] >>> 1) : s[k];
            s[k] = v;
        end
        r = {w16(s[0]), w16(s[1]), w16(s[2]), w16(s[3])};
        return r;
    endfunction

    function automatic op_t mk(input logic [15:0] ar, ai, br, bi, wr, wi, input logic iv);
        op_t o;
        o.a = '{re: ar, im: ai};
        o.b = '{re: br, im: bi};
        o.w = '{re: wr, im: wi};
        o.inv = iv;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    endfunction

    // Drive one cycle's inputs just after a falling edge, sample, then advance one clock.
    task automatic step(input logic vin, input op_t o, input logic ordy, output obs_t ob);
        in_valid  = vin;
        a_r = o.a.re; a_i = o.a.im;
        b_r = o.b.re; b_i = o.b.im;
        w_r = o.w.re; w_i = o.w.im;
        inv       = o.inv;
        out_ready = ordy;
        #1;
        ob.ov0 = ov0;
        ob.ov1 = ov1;
        ob.ir0 = ir0;
        ob.ir1 = ir1;
        ob.d0  = {x1r, x1i, x2r, x2i};
        ob.d1  = {y1r, y1i, y2r, y2i};
        if (rst_n && vin && ir0) begin
            q0.push_back(model(o, 0));
            q1.push_back(model(o, 1));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t ob;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) step(1'b0, '0, 1'b0, ob);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, ob);
        step(1'b0, '0, 1'b0, ob);
        n_cmp++; if (ob.ov0 !== 1'b0) begin n_err++; $display("FAIL reset_ov0 got=%b exp=0", ob.ov0); end
        n_cmp++; if (ob.ov1 !== 1'b0) begin n_err++; $display("FAIL reset_ov1 got=%b exp=0", ob.ov1); end
        n_cmp++; if (ob.ir0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready0 got=%b exp=1", ob.ir0); end
        n_cmp++; if (ob.ir1 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready1 got=%b exp=1", ob.ir1); end
        n_cmp++; if (ob.d0 !== 64'h0) begin n_err++; $display("FAIL reset_data0 got=%h exp=0", ob.d0); end
        n_cmp++; if (ob.d1 !== 64'h0) begin n_err++; $display("FAIL reset_data1 got=%h exp=0", ob.d1); end
        q0.delete();
        q1.delete();
    endtask

    task automatic test_directed();
        op_t  ops[7];
        res_t e0[7], e1[7];
        obs_t ob;
        ops[0] = mk(ONE, 16'h0, ONE, 16'h0, ONE, 16'h0, 1'b0);
        e0[0] = {16'h0200, 16'h0000, 16'h0000, 16'h0000};
        e1[0] = {16'h0100, 16'h0000, 16'h0000, 16'h0000};
        ops[1] = mk(ONE, 16'h0, ONE, 16'h0, 16'h0, ONE, 1'b0);
        e0[1] = {16'h0100, 16'h0100, 16'h0100, 16'hFF00};
        e1[1] = {16'h0080, 16'h0080, 16'h0080, 16'hFF80};
        ops[2] = mk(ONE, 16'h0, ONE, 16'h0, 16'h0, ONE, 1'b1);
        e0[2] = {16'h0100, 16'hFF00, 16'h0100, 16'h0100};
        e1[2] = {16'h0080, 16'hFF80, 16'h0080, 16'h0080};
        ops[3] = mk(NEG_ONE, 16'h0, 16'h0, 16'h0, ONE, 16'h0, 1'b0);
        e0[3] = {16'hFF00, 16'h0000, 16'hFF00, 16'h0000};
        e1[3] = {16'hFF80, 16'h0000, 16'hFF80, 16'h0000};
        ops[4] = mk(16'hFFFF, 16'h0001, 16'h0, 16'h0, ONE, 16'h0, 1'b0);
        e0[4] = {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
        e1[4] = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        ops[5] = mk(16'h7F00, 16'h0, ONE, 16'h0, ONE, 16'h0, 1'b0);
        e0[5] = {16'h8000, 16'h0000, 16'h7E00, 16'h0000};
        e1[5] = {16'h4000, 16'h0000, 16'h3F00, 16'h0000};
        ops[6] = mk(16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0080, 16'h0, 1'b0);
        e0[6] = {16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
        e1[6] = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        for (int k = 0; k < 7; k++) begin
            step(1'b1, ops[k], 1'b1, ob);
            step(1'b0, '0, 1'b1, ob);
            step(1'b0, '0, 1'b1, ob);
            n_cmp++; if (ob.ov0 !== 1'b0) begin n_err++; $display("FAIL dir%0d_early_valid got=%b exp=0", k, ob.ov0); end
            step(1'b0, '0, 1'b1, ob);
            n_cmp++; if (ob.ov0 !== 1'b1) begin n_err++; $display("FAIL dir%0d_latency got=%b exp=1", k, ob.ov0); end
            n_cmp++; if (ob.d0 !== e0[k]) begin n_err++; $display("FAIL dir%0d_scale0 got=%h exp=%h", k, ob.d0, e0[k]); end
            n_cmp++; if (ob.d1 !== e1[k]) begin n_err++; $display("FAIL dir%0d_scale1 got=%h exp=%h", k, ob.d1, e1[k]); end
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic test_random();
        obs_t ob;
        op_t  op;
        logic vin, ordy, held;
        res_t hd0, hd1, e0, e1;
        held = 1'b0;
        hd0  = '0;
        hd1  = '0;
        for (int c = 0; c < 460; c++) begin
            vin  = (c < 400) && ($urandom_range(0, 3) != 0);
            ordy = (c >= 400) || ($urandom_range(0, 3) != 0);
            op   = rand_op();
            step(vin, op, ordy, ob);
            if (held) begin
                n_cmp++;
                if (ob.ov0 !== 1'b1 || ob.d0 !== hd0 || ob.d1 !== hd1) begin
                    n_err++;
                    $display("FAIL rand_hold cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, ob.ov0, ob.d0, ob.d1, hd0, hd1);
                end
            end
            if (ob.ov0 === 1'b1 && ordy) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra cyc=%0d got=%h exp=none", c, ob.d0);
                end else begin
                    e0 = q0.pop_front();
                    e1 = q1.pop_front();
                    if (ob.d0 !== e0 || ob.d1 !== e1) begin
                        n_err++;
                        $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", c, ob.d0, ob.d1, e0, e1);
                    end
                end
            end
            held = (ob.ov0 === 1'b1) && !ordy;
            hd0  = ob.d0;
            hd1  = ob.d1;
        end
        n_cmp++;
        if (q0.size() != 0) begin n_err++; $display("FAIL rand_lost got=%0d pending exp=0", q0.size()); end
        q0.delete();
        q1.delete();
    endtask

    task automatic test_back_to_back();
        obs_t ob;
        logic vin, ordy, held;
        res_t hd0, e0, e1;
        op_t  ops[6];
        int   sent, got;
        for (int k = 0; k < 6; k++) ops[k] = rand_op();
        sent = 0;
        got  = 0;
        held = 1'b0;
        hd0  = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            vin  = (sent < 6);
            ordy = !(c >= 2 && c <= 6);
            step(vin, (sent < 6) ? ops[sent] : op_t'('0), ordy, ob);
            if (vin && ob.ir0 === 1'b1) sent++;
            if (ob.ov0 === 1'b1 && !ordy) begin
                n_cmp++;
                if (ob.ir0 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, ob.ir0); end
            end
            if (held) begin
                n_cmp++;
                if (ob.d0 !== hd0 || ob.ov0 !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", c, ob.ov0, ob.d0, hd0);
                end
            end
            if (ob.ov0 === 1'b1 && ordy) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra cyc=%0d got=%h exp=none", c, ob.d0);
                end else begin
                    e0 = q0.pop_front();
                    e1 = q1.pop_front();
                    got++;
                    if (ob.d0 !== e0 || ob.d1 !== e1) begin
                        n_err++;
                        $display("FAIL bp_data idx=%0d got=%h/%h exp=%h/%h", got - 1, ob.d0, ob.d1, e0, e1);
                    end
                end
            end
            held = (ob.ov0 === 1'b1) && !ordy;
            hd0  = ob.d0;
        end
        n_cmp++;
        if (got != 6) begin n_err++; $display("FAIL bp_count got=%0d exp=6", got); end
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset_midstream();
        obs_t ob;
        op_t  op;
        res_t e0, e1;
        step(1'b1, rand_op(), 1'b1, ob);
        step(1'b1, rand_op(), 1'b1, ob);
        rst_n = 1'b0;
        step(1'b0, '0, 1'b1, ob);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        step(1'b0, '0, 1'b1, ob);
        n_cmp++; if (ob.ov0 !== 1'b0 || ob.ov1 !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b%b exp=00", ob.ov0, ob.ov1); end
        n_cmp++; if (ob.d0 !== 64'h0 || ob.d1 !== 64'h0) begin n_err++; $display("FAIL midrst_data got=%h/%h exp=0", ob.d0, ob.d1); end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, '0, 1'b1, ob);
            n_cmp++; if (ob.ov0 !== 1'b0) begin n_err++; $display("FAIL midrst_ghost cyc=%0d got=%b exp=0", c, ob.ov0); end
        end
        op = rand_op();
        step(1'b1, op, 1'b1, ob);
        step(1'b0, '0, 1'b1, ob);
        step(1'b0, '0, 1'b1, ob);
        n_cmp++; if (ob.ov0 !== 1'b0) begin n_err++; $display("FAIL midrst_early got=%b exp=0", ob.ov0); end
        step(1'b0, '0, 1'b1, ob);
        n_cmp++; if (ob.ov0 !== 1'b1) begin n_err++; $display("FAIL midrst_latency got=%b exp=1", ob.ov0); end
        e0 = model(op, 0);
        e1 = model(op, 1);
        n_cmp++; if (ob.d0 !== e0 || ob.d1 !== e1) begin n_err++; $display("FAIL midrst_data_after got=%h/%h exp=%h/%h", ob.d0, ob.d1, e0, e1); end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
